// File: rtl/wb_ram_ctrl.sv
// Wishbone B4 registered-feedback slave driving the write/read ports of a simple dual-port word RAM.
// Handles classic cycles and incrementing bursts (linear, wrap-4/8/16), with error on out-of-window.
module wb_ram_ctrl #(
    parameter int unsigned depth = 4096,
    localparam int unsigned AW = $clog2(depth)
) (
    input  logic          clk,
    input  logic          resetn,

    input  logic [31:0]   wb_adr_i,
    input  logic [31:0]   wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [31:0]   wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,

    output logic [3:0]    ram_we,
    output logic [31:0]   ram_din,
    output logic [AW-1:0] ram_waddr,
    output logic [AW-1:0] ram_raddr,
    input  logic [31:0]   ram_dout
);

    // Controller state is carried entirely by the two handshake registers:
    // idle = neither set, ack = ack_q, err = err_q (mutually exclusive).
    logic ack_q;
    logic err_q;

    logic          req;
    logic          oor;
    logic          burst_cont;
    logic          linear;
    logic          nxt_oor;
    logic [AW-1:0] cur;
    logic [AW-1:0] nxt;
    logic [AW-1:0] wrap_mask;
    logic          unused_adr;

    assign req        = wb_cyc_i & wb_stb_i;
    assign cur        = wb_adr_i[AW+1:2];
    assign oor        = |wb_adr_i[31:AW+2];
    assign burst_cont = (wb_cti_i == 3'b010);
    assign linear     = (wb_bte_i == 2'b00);
    assign unused_adr = ^wb_adr_i[1:0];

    // Bits under wrap_mask increment and wrap; bits above it are held.
    always_comb begin
        wrap_mask = '1;
        unique case (wb_bte_i)
            2'b00: wrap_mask = '1;
            2'b01: wrap_mask = AW'(3);
            2'b10: wrap_mask = AW'(7);
            2'b11: wrap_mask = AW'(15);
        endcase
        nxt = (cur & ~wrap_mask) | ((cur + 1'b1) & wrap_mask);
    end

    // A linear burst stepping past the last word leaves the RAM window.
    assign nxt_oor = oor | (linear & (&cur));

    always_comb begin
        ram_raddr = cur;
        if (ack_q && req && burst_cont && !wb_we_i) begin
            ram_raddr = nxt;
        end
    end

    always_comb begin
        ram_we = 4'b0000;
        if (ack_q && req && wb_we_i && !oor) begin
            ram_we = wb_sel_i;
        end
    end

    assign ram_din   = wb_dat_i;
    assign ram_waddr = cur;
    assign wb_dat_o  = ram_dout;
    assign wb_ack_o  = ack_q;
    assign wb_err_o  = err_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (err_q) begin
                // Error is a single-cycle response; fall back to idle.
            end else if (ack_q) begin
                if (req && burst_cont) begin
                    if (nxt_oor) begin
                        err_q <= 1'b1;
                    end else begin
                        ack_q <= 1'b1;
                    end
                end
            end else if (req) begin
                if (oor) begin
                    err_q <= 1'b1;
                end else begin
                    ack_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_ram_ctrl.sv
// Self-checking bench for wb_ram_ctrl: table of classic accesses plus hand-written burst,
// out-of-range and mid-burst reset sequences against a behavioural dual-port RAM.
module tb_wb_ram_ctrl;

    localparam int unsigned DEPTH = 4096;
    localparam int unsigned AW    = 12;

    logic          clk = 1'b0;
    logic          resetn;
    logic [31:0]   adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
    logic          we;
    logic          cyc;
    logic          stb;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic          wb_err_o;
    logic [3:0]    ram_we;
    logic [31:0]   ram_din;
    logic [AW-1:0] ram_waddr;
    logic [AW-1:0] ram_raddr;
    logic [31:0]   ram_dout;

    always #5 clk = ~clk;

    wb_ram_ctrl #(.depth(DEPTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .wb_adr_i  (adr),
        .wb_dat_i  (dat),
        .wb_sel_i  (sel),
        .wb_we_i   (we),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_cti_i  (cti),
        .wb_bte_i  (bte),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .wb_err_o  (wb_err_o),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_waddr (ram_waddr),
        .ram_raddr (ram_raddr),
        .ram_dout  (ram_dout)
    );

    // Behavioural model of the synchronous-read dual-port RAM.
    logic [31:0] mem [DEPTH];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we[i]) mem[ram_waddr][8*i +: 8] <= ram_din[8*i +: 8];
        end
        ram_dout <= mem[ram_raddr];
    end

    int we_pulses = 0;
    always @(posedge clk) begin
        if (|ram_we) we_pulses <= we_pulses + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
        adr = 32'h0; dat = 32'h0; sel = 4'h0;
    endtask

    // Classic cycle; hs = {ack,err} sampled in cycles 0, 1 and 2.
    task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [5:0] hs,
                           output logic [31:0] rd, output int pulses);
        int p0;
        p0 = we_pulses;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s; cti = 3'b000; bte = 2'b00;
        @(negedge clk); hs[5:4] = {wb_ack_o, wb_err_o};
        @(posedge clk); #1;
        @(negedge clk); hs[3:2] = {wb_ack_o, wb_err_o}; rd = wb_dat_o;
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk); hs[1:0] = {wb_ack_o, wb_err_o};
        @(posedge clk); #1;
        pulses = we_pulses - p0;
    endtask

    logic [31:0]   b_adr [16];
    logic [31:0]   b_dat [16];
    logic [31:0]   b_rd  [16];
    logic [AW-1:0] b_raddr [20];
    int            b_acks;
    int            b_errs;
    int            b_last_c;
    int            b_pulses;
    logic [1:0]    b_tail;
    logic [1:0]    b_rst_ack;

    // Registered-feedback master: advances to the next beat after each ack.
    task automatic burst(input logic w, input logic [1:0] bt, input int n, input int rst_cycle);
        int   b;
        int   p0;
        logic done;
        b = 0; done = 1'b0; b_acks = 0; b_errs = 0; b_last_c = -1; b_rst_ack = 2'b00;
        p0 = we_pulses;
        cyc = 1'b1; stb = 1'b1; we = w; bte = bt; sel = 4'hF;
        adr = b_adr[0]; dat = b_dat[0]; cti = (n == 1) ? 3'b111 : 3'b010;
        for (int c = 0; c < n + 3 && !done; c++) begin
            if (c == rst_cycle) begin
                #2;
                b_rst_ack[1] = wb_ack_o;
                resetn = 1'b0;
                #1;
                b_rst_ack[0] = wb_ack_o | wb_err_o;
                bus_idle();
                done = 1'b1;
            end else begin
                @(negedge clk);
                b_raddr[c] = ram_raddr;
                if (wb_err_o) begin
                    b_errs++; done = 1'b1; b_last_c = c;
                end else if (wb_ack_o) begin
                    b_rd[b] = wb_dat_o; b++; b_acks++; b_last_c = c;
                    if (b == n) done = 1'b1;
                end
                @(posedge clk); #1;
                if (done) begin
                    bus_idle();
                end else begin
                    adr = b_adr[b]; dat = b_dat[b];
                    cti = (b == n - 1) ? 3'b111 : 3'b010;
                end
            end
        end
        bus_idle();
        @(negedge clk); b_tail = {wb_ack_o, wb_err_o};
        @(posedge clk); #1;
        b_pulses = we_pulses - p0;
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [5:0]  hs;
        int          pulses;
        logic        chk;
        logic [31:0] rd;
    } vec_t;

    localparam logic [5:0] HS_ACK = 6'b001000;
    localparam logic [5:0] HS_ERR = 6'b000100;

    vec_t        vecs [15];
    logic [5:0]  hs;
    logic [31:0] rd;
    int          pulses;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, HS_ACK, 1, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, HS_ACK, 0, 1'b1, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, HS_ACK, 1, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, HS_ACK, 1, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, HS_ACK, 0, 1'b1, 32'h11BB_33DD};
        vecs[5]  = '{1'b1, 32'h0000_0024, 32'h9999_0009, 4'hF, HS_ACK, 1, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_0028, 32'hAAAA_000A, 4'hF, HS_ACK, 1, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 32'h0000_002C, 32'hBBBB_000B, 4'hF, HS_ACK, 1, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 32'h0000_0038, 32'h0BAD_F00D, 4'hF, HS_ACK, 1, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 32'h0000_3FFC, 32'hCAFE_F00D, 4'hF, HS_ACK, 1, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_3FFC, 32'h0,         4'hF, HS_ACK, 0, 1'b1, 32'hCAFE_F00D};
        vecs[11] = '{1'b0, 32'h0000_4000, 32'h0,         4'hF, HS_ERR, 0, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 32'h0000_4010, 32'h1234_5678, 4'hF, HS_ERR, 0, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 32'h8000_0010, 32'h0,         4'hF, HS_ERR, 0, 1'b0, 32'h0};
        vecs[14] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, HS_ACK, 0, 1'b1, 32'hDEAD_BEEF};

        bus_idle();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {wb_ack_o, wb_err_o, ram_we}, 64'h0);
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            classic(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, hs, rd, pulses);
            check($sformatf("vec%0d_handshake", i), hs, vecs[i].hs);
            check($sformatf("vec%0d_we_pulses", i), pulses, vecs[i].pulses);
            if (vecs[i].chk) check($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
        end

        // Linear read burst of 4 beats from word 8.
        b_adr[0] = 32'h20; b_adr[1] = 32'h24; b_adr[2] = 32'h28; b_adr[3] = 32'h2C;
        burst(1'b0, 2'b00, 4, -1);
        check("lin_rd_acks", b_acks, 4);
        check("lin_rd_last_cycle", b_last_c, 4);
        check("lin_rd_pulses", b_pulses, 0);
        check("lin_rd_tail", b_tail, 2'b00);
        check("lin_rd_data", {b_rd[0], b_rd[1]}, {32'h11BB_33DD, 32'h9999_0009});
        check("lin_rd_data2", {b_rd[2], b_rd[3]}, {32'hAAAA_000A, 32'hBBBB_000B});
        check("lin_rd_raddr", {b_raddr[0], b_raddr[1], b_raddr[2], b_raddr[3]},
              {12'd8, 12'd9, 12'd10, 12'd11});

        // Wrap-4 read burst from word 10: 10, 11, 8, 9.
        b_adr[0] = 32'h28; b_adr[1] = 32'h2C; b_adr[2] = 32'h20; b_adr[3] = 32'h24;
        burst(1'b0, 2'b01, 4, -1);
        check("wrap_rd_acks", b_acks, 4);
        check("wrap_rd_raddr", {b_raddr[0], b_raddr[1], b_raddr[2], b_raddr[3]},
              {12'd10, 12'd11, 12'd8, 12'd9});
        check("wrap_rd_data", {b_rd[2], b_rd[3]}, {32'h11BB_33DD, 32'h9999_0009});

        // Wrap-4 write burst from word 6: 6, 7, 4, 5.
        b_adr[0] = 32'h18; b_adr[1] = 32'h1C; b_adr[2] = 32'h10; b_adr[3] = 32'h14;
        b_dat[0] = 32'hA6A6_0006; b_dat[1] = 32'hA7A7_0007;
        b_dat[2] = 32'hA4A4_0004; b_dat[3] = 32'hA5A5_0005;
        burst(1'b1, 2'b01, 4, -1);
        check("wrap_wr_acks", b_acks, 4);
        check("wrap_wr_last_cycle", b_last_c, 4);
        check("wrap_wr_pulses", b_pulses, 4);
        for (int i = 0; i < 4; i++) begin
            classic(1'b0, 32'h10 + 32'(4 * i), 32'h0, 4'hF, hs, rd, pulses);
            check($sformatf("wrap_wr_readback_w%0d", 4 + i), rd,
                  {8'hA4 + 8'(i), 8'hA4 + 8'(i), 16'(4 + i)});
        end
        classic(1'b0, 32'h20, 32'h0, 4'hF, hs, rd, pulses);
        check("wrap_wr_word8_untouched", rd, 32'h11BB_33DD);

        // Linear burst starting at the last word overruns the window on beat 2.
        b_adr[0] = 32'h3FFC; b_adr[1] = 32'h4000;
        burst(1'b0, 2'b00, 2, -1);
        check("overrun_acks", b_acks, 1);
        check("overrun_errs", b_errs, 1);
        check("overrun_err_cycle", b_last_c, 2);
        check("overrun_err_one_cycle", b_tail, 2'b00);
        check("overrun_first_data", b_rd[0], 32'hCAFE_F00D);

        // Reset during the third beat of a write burst to words 12..15.
        b_adr[0] = 32'h30; b_adr[1] = 32'h34; b_adr[2] = 32'h38; b_adr[3] = 32'h3C;
        b_dat[0] = 32'hC0DE_0012; b_dat[1] = 32'hC0DE_0013;
        b_dat[2] = 32'hC0DE_0014; b_dat[3] = 32'hC0DE_0015;
        burst(1'b1, 2'b00, 4, 3);
        check("rst_ack_falls", b_rst_ack, 2'b10);
        check("rst_pulses", b_pulses, 2);
        check("rst_tail", b_tail, 2'b00);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        classic(1'b0, 32'h30, 32'h0, 4'hF, hs, rd, pulses);
        check("rst_word12", rd, 32'hC0DE_0012);
        classic(1'b0, 32'h38, 32'h0, 4'hF, hs, rd, pulses);
        check("rst_word14_untouched", rd, 32'h0BAD_F00D);
        classic(1'b1, 32'h3C, 32'h5A5A_5A5A, 4'hF, hs, rd, pulses);
        check("post_rst_wr_handshake", hs, HS_ACK);
        check("post_rst_wr_pulses", pulses, 1);
        classic(1'b0, 32'h3C, 32'h0, 4'hF, hs, rd, pulses);
        check("post_rst_rd", rd, 32'h5A5A_5A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
